// File: rtl/ram_bus_port_pkg.sv
// Shared definitions for the RAM bus port: state encoding and default bus/address widths.
package ram_bus_port_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t RD_WAIT = 2'd1;
  localparam state_t WR_WAIT = 2'd2;

endpackage

// File: rtl/ram_bus_port.sv
// Memory-side stage between the wired-OR data bus and the RAM array; sequences ready-handshaked
// reads/writes. Define RAM_TIMEOUT_EN to enable the mem_ready wait timeout and sticky err flag.
module ram_bus_port
  import ram_bus_port_pkg::*;
#(
  parameter int unsigned word_width     = DEFAULT_WORD_WIDTH,
  parameter int unsigned addr_width     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] bus_in,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic                  drive_en,
  output logic [word_width-1:0] bus_out,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  input  logic [word_width-1:0] mem_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_ready,
  output logic                  err
);

  state_t                  state_q, state_d;
  logic [word_width-1:0]   data_q, data_d;
  logic [word_width-1:0]   wdata_q, wdata_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    done_q, done_d;

`ifdef RAM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(timeout_cycles - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    done_d   = 1'b0;
`ifdef RAM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read; the read request is simply dropped.
        if (wr_req) begin
          addr_d   = addr_in[addr_width-1:0];
          wdata_d  = bus_in;
          mem_wr_d = 1'b1;
          state_d  = WR_WAIT;
`ifdef RAM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else if (rd_req) begin
          addr_d   = addr_in[addr_width-1:0];
          mem_rd_d = 1'b1;
          state_d  = RD_WAIT;
`ifdef RAM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ready) begin
          if (state_q == RD_WAIT) data_d = mem_rdata;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
`ifdef RAM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          if (state_q == RD_WAIT) data_d = '1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      done_q   <= done_d;
    end
  end

`ifdef RAM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(timeout_cycles);
  assign err = 1'b0;
`endif

  if (word_width > addr_width) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_in[word_width-1:addr_width];
  end

  // Wired-OR bus: contribute zero whenever the control unit is not selecting us.
  assign bus_out   = drive_en ? data_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: doc/ram_bus_port.md
Name: ram_bus_port

Overview:
- Memory-side stage that sits between the shared wired-OR data bus and the RAM array.
- Consumes the bus value (ram_out) as write data.
- Produces read data onto the bus through the ram_in input, which is ORed into the bus.
- Sequences multi-cycle RAM reads and writes with a ready handshake.
- Holds read data and drives it onto the bus only while the control unit enables it; otherwise it drives all-zero, as the wired-OR bus requires.

Parameters:
- word_width, 32, width of bus and RAM data.
- addr_width, 16, RAM address width; taken from the low bits of the address register.
- timeout_cycles, 255, maximum mem_ready wait; used only with RAM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_in  in  word_width  address register (AM) value; bits [addr_width-1:0] are used.
- bus_in  in  word_width  bus value (ram_out); write data.
- rd_req  in  1  single-cycle read request from the control unit.
- wr_req  in  1  single-cycle write request from the control unit.
- drive_en  in  1  control unit enable for driving held read data onto the bus.
- bus_out  out  word_width  to bus ram_in; equals data_q when drive_en is 1, else zero.
- busy  out  1  high while an access is in flight.
- done  out  1  one-cycle pulse when an access completes.
- mem_addr  out  addr_width  RAM address.
- mem_wdata  out  word_width  RAM write data.
- mem_rdata  in  word_width  RAM read data; valid with mem_ready.
- mem_rd  out  1  RAM read strobe; held until mem_ready.
- mem_wr  out  1  RAM write strobe; held until mem_ready.
- mem_ready  in  1  RAM completion.
- err  out  1  sticky timeout flag; constant 0 when RAM_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - data_q, addr_q, wdata_q = 0.
  - mem_rd, mem_wr, busy, done, err = 0.
  - bus_out = 0 regardless of drive_en, because data_q = 0.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE:
  - wr_req=1: latch addr_q and wdata_q=bus_in; go to WR_WAIT. wr_req has priority when both requests are high; rd_req is dropped.
  - rd_req=1 (wr_req=0): latch addr_q; go to RD_WAIT.
- RD_WAIT:
  - mem_rd=1 and busy=1.
  - On mem_ready=1: data_q<=mem_rdata; done=1 in the next cycle; return to IDLE.
- WR_WAIT:
  - mem_wr=1 and busy=1; mem_wdata=wdata_q.
  - On mem_ready=1: done=1 in the next cycle; return to IDLE; data_q is unchanged.
- Outputs:
  - mem_addr = addr_q; mem_rd and mem_wr are registered outputs.
  - mem_ready seen in the same cycle the strobe first rises completes the access; minimum latency is request -> done = 2 cycles.
  - mem_ready in IDLE is ignored.
- Requests while busy=1 are ignored, not queued.
- data_q persists until the next completed read, so drive_en may be asserted any number of cycles after done.
- bus_out is combinational from drive_en and data_q; no bus contention logic is needed beyond zero-when-disabled.
- drive_en=1 during a write: bus_out = data_q. Loop-back is prevented by the control unit; the block does not gate it.
- Reset mid-access: strobes drop immediately and the access is lost.

Optional Feature:
- Macro: RAM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entering RD_WAIT or WR_WAIT and increments each waiting cycle.
  - When it reaches timeout_cycles without mem_ready: abort to IDLE, done=1, err<=1 (sticky until reset).
  - On read abort, data_q <= all-ones.
- Undefined: no counter; the block waits indefinitely; err is tied 0.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2) and the default word_width/addr_width constants used by the bus and register blocks.
- No sub-module: the FSM and datapath are a single module.

Test Plan:
- Reset, then drive_en=1 with no access -> bus_out=0, busy=0, mem_rd=mem_wr=0.
- addr_in=0x0010, rd_req pulse, mem_ready after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x0010, done pulses once; bus_out=0 until drive_en=1, then 0xDEADBEEF.
- bus_in=0x12345678, addr_in=0x0004, wr_req pulse, mem_ready immediate -> mem_wr for 1 cycle with mem_wdata=0x12345678, done at cycle 2.
- rd_req and wr_req together -> write performed, no read strobe; a second rd_req while busy=1 -> ignored.
- rst_n=0 during RD_WAIT -> mem_rd=0 asynchronously, data_q=0; a later mem_ready is ignored.
- RAM_TIMEOUT_EN, timeout_cycles=4, read with mem_ready held 0 -> abort after 4 wait cycles, done=1, err=1, bus_out=0xFFFFFFFF with drive_en=1.
